// File: rtl/cascade_alu_slice_exec_if.sv
// Execute-stage handshake and operand bus for the cascaded slice ALU.
interface cascade_alu_slice_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_flag;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic [1:0]       sel_c;
    logic             reverse;
    logic             clearA_bar;
    logic             clearB_bar;
    logic [WIDTH-1:0] result;
    logic             n_out;
    logic             z_out;
    logic             c_out;
    logic             v_out;
    logic             busy;
    logic             done;

    // Requester side: drives operands/control, receives result and flags.
    modport master (
        output start, a, b, c_flag, alu_s, alu_m, sel_c, reverse, clearA_bar, clearB_bar,
        input  result, n_out, z_out, c_out, v_out, busy, done
    );

    // ALU side.
    modport slave (
        input  start, a, b, c_flag, alu_s, alu_m, sel_c, reverse, clearA_bar, clearB_bar,
        output result, n_out, z_out, c_out, v_out, busy, done
    );
endinterface

// File: rtl/cascade_alu_slice_exec.sv
// Cascaded slice ALU: evaluates one SLICE-bit slice per clock, LSB first,
// with the inter-slice ripple carry held in a register.
module cascade_alu_slice_exec #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic                      clk,
    input  logic                      clear,
    cascade_alu_slice_exec_if.slave   io_alu
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SUM_W  = SLICE + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic              r_carry,  w_carry_nxt;
    logic [WIDTH-1:0]  r_x,      w_x_nxt;
    logic [WIDTH-1:0]  r_y,      w_y_nxt;
    logic              r_ci,     w_ci_nxt;
    logic              r_m,      w_m_nxt;
    logic [3:0]        r_s,      w_s_nxt;
    logic              r_cf,     w_cf_nxt;
    logic [WIDTH-1:0]  r_result, w_result_nxt;
    logic              r_n,      w_n_nxt;
    logic              r_z,      w_z_nxt;
    logic              r_c,      w_c_nxt;
    logic              r_v,      w_v_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_done,   w_done_nxt;

    logic [WIDTH-1:0]  w_y_eff;
    int unsigned       w_sh;
    logic [SLICE-1:0]  w_x_sl;
    logic [SLICE-1:0]  w_y_sl;
    logic [SLICE-1:0]  w_ye_sl;
    logic              w_cin;
    logic [SUM_W-1:0]  w_sum;
    logic [SLICE-1:0]  w_logic;
    logic [SLICE-1:0]  w_slice;
    logic              w_cout;
    logic [WIDTH-1:0]  w_mask;
    logic [WIDTH-1:0]  w_res_ins;
    logic [WIDTH-1:0]  w_a_p;
    logic [WIDTH-1:0]  w_b_p;
    logic              w_ci_cap;

    assign io_alu.result = r_result;
    assign io_alu.n_out  = r_n;
    assign io_alu.z_out  = r_z;
    assign io_alu.c_out  = r_c;
    assign io_alu.v_out  = r_v;
    assign io_alu.busy   = r_busy;
    assign io_alu.done   = r_done;

    // Effective arithmetic Y: added, subtracted (one's complement) or dropped.
    always_comb begin
        w_y_eff = '0;
        if (r_s == 4'b1001) begin
            w_y_eff = r_y;
        end else if (r_s == 4'b0110) begin
            w_y_eff = ~r_y;
        end
    end

    // Current slice evaluation and its insertion into the result word.
    always_comb begin
        w_sh    = 32'(r_cnt) * SLICE;
        w_x_sl  = SLICE'(r_x >> w_sh);
        w_y_sl  = SLICE'(r_y >> w_sh);
        w_ye_sl = SLICE'(w_y_eff >> w_sh);
        w_cin   = (r_cnt == '0) ? r_ci : r_carry;
        w_sum   = {1'b0, w_x_sl} + {1'b0, w_ye_sl} + SUM_W'(w_cin);
        w_logic = '0;
        case (r_s)
            4'b0000: w_logic = ~w_x_sl;
            4'b0001: w_logic = ~(w_x_sl & w_y_sl);
            4'b0010: w_logic = ~w_x_sl | w_y_sl;
            4'b0011: w_logic = '1;
            4'b0100: w_logic = ~(w_x_sl | w_y_sl);
            4'b0101: w_logic = ~w_y_sl;
            4'b0110: w_logic = ~(w_x_sl ^ w_y_sl);
            4'b0111: w_logic = w_x_sl | ~w_y_sl;
            4'b1000: w_logic = ~w_x_sl & w_y_sl;
            4'b1001: w_logic = w_x_sl ^ w_y_sl;
            4'b1010: w_logic = w_y_sl;
            4'b1011: w_logic = w_x_sl | w_y_sl;
            4'b1100: w_logic = '0;
            4'b1101: w_logic = w_x_sl & ~w_y_sl;
            4'b1110: w_logic = w_x_sl & w_y_sl;
            default: w_logic = w_x_sl;
        endcase
        w_slice   = r_m ? w_sum[SLICE-1:0] : w_logic;
        w_cout    = r_m & w_sum[SLICE];
        w_mask    = WIDTH'({SLICE{1'b1}}) << w_sh;
        w_res_ins = (r_result & ~w_mask) | (WIDTH'(w_slice) << w_sh);
    end

    // Operand clearing and carry-in selection applied at capture.
    always_comb begin
        w_a_p = io_alu.clearA_bar ? io_alu.a : '0;
        w_b_p = io_alu.clearB_bar ? io_alu.b : '0;
        case (io_alu.sel_c)
            2'b00:   w_ci_cap = 1'b0;
            2'b01:   w_ci_cap = 1'b1;
            2'b10:   w_ci_cap = ~io_alu.c_flag;
            default: w_ci_cap = io_alu.c_flag;
        endcase
    end

    // Next-state and register-update logic for the IDLE/RUN controller.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_carry_nxt  = r_carry;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_ci_nxt     = r_ci;
        w_m_nxt      = r_m;
        w_s_nxt      = r_s;
        w_cf_nxt     = r_cf;
        w_result_nxt = r_result;
        w_n_nxt      = r_n;
        w_z_nxt      = r_z;
        w_c_nxt      = r_c;
        w_v_nxt      = r_v;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_alu.start) begin
                    w_x_nxt     = io_alu.reverse ? w_b_p : w_a_p;
                    w_y_nxt     = io_alu.reverse ? w_a_p : w_b_p;
                    w_ci_nxt    = w_ci_cap;
                    w_m_nxt     = io_alu.alu_m;
                    w_s_nxt     = io_alu.alu_s;
                    w_cf_nxt    = io_alu.c_flag;
                    w_cnt_nxt   = '0;
                    w_carry_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_result_nxt = w_res_ins;
                w_carry_nxt  = w_cout;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_n_nxt     = w_res_ins[WIDTH-1];
                    w_z_nxt     = (w_res_ins == '0);
                    w_c_nxt     = r_m ? w_cout : r_cf;
                    w_v_nxt     = r_m & (r_x[WIDTH-1] == w_y_eff[WIDTH-1])
                                      & (w_res_ins[WIDTH-1] != r_x[WIDTH-1]);
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; clear aborts any operation in flight.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_ci     <= 1'b0;
            r_m      <= 1'b0;
            r_s      <= '0;
            r_cf     <= 1'b0;
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_carry  <= w_carry_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_ci     <= w_ci_nxt;
            r_m      <= w_m_nxt;
            r_s      <= w_s_nxt;
            r_cf     <= w_cf_nxt;
            r_result <= w_result_nxt;
            r_n      <= w_n_nxt;
            r_z      <= w_z_nxt;
            r_c      <= w_c_nxt;
            r_v      <= w_v_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end
endmodule

// File: tb/tb_cascade_alu_slice_exec.sv
// Scoreboard bench for the cascaded slice ALU.
module tb_cascade_alu_slice_exec;
    typedef struct packed {
        logic [31:0] r;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic clear;
    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];

    cascade_alu_slice_exec_if #(.WIDTH(32)) bus ();

    cascade_alu_slice_exec #(.WIDTH(32), .SLICE(4)) dut (
        .clk    (clk),
        .clear  (clear),
        .io_alu (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input logic [31:0] r, input logic n, z, c, v);
        exp_t e;
        e.r = r; e.n = n; e.z = z; e.c = c; e.v = v;
        return e;
    endfunction

    // Full-width reference model of one operation.
    function automatic exp_t model(input logic [31:0] a, b, input logic cf, input logic [3:0] s,
                                   input logic m, input logic [1:0] sc,
                                   input logic rev, ca, cb);
        logic [31:0] ap, bp, x, y, ye, r;
        logic        ci;
        logic [32:0] sum;
        exp_t        e;
        ap = ca ? a : 32'h0;
        bp = cb ? b : 32'h0;
        x  = rev ? bp : ap;
        y  = rev ? ap : bp;
        ci = (sc == 2'b00) ? 1'b0 : (sc == 2'b01) ? 1'b1 : (sc == 2'b10) ? ~cf : cf;
        if (m) begin
            ye  = (s == 4'b1001) ? y : (s == 4'b0110) ? ~y : 32'h0;
            sum = {1'b0, x} + {1'b0, ye} + {32'h0, ci};
            r   = sum[31:0];
            e.c = sum[32];
            e.v = (x[31] == ye[31]) && (r[31] != x[31]);
        end else begin
            case (s)
                4'h0: r = ~x;         4'h1: r = ~(x & y);
                4'h2: r = ~x | y;     4'h3: r = 32'hFFFF_FFFF;
                4'h4: r = ~(x | y);   4'h5: r = ~y;
                4'h6: r = ~(x ^ y);   4'h7: r = x | ~y;
                4'h8: r = ~x & y;     4'h9: r = x ^ y;
                4'hA: r = y;          4'hB: r = x | y;
                4'hC: r = 32'h0;      4'hD: r = x & ~y;
                4'hE: r = x & y;      default: r = x;
            endcase
            e.c = cf;
            e.v = 1'b0;
        end
        e.r = r;
        e.n = r[31];
        e.z = (r == 32'h0);
        return e;
    endfunction

    // Compares every produced result against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t got;
            exp_t want;
            got = {bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out};
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result=%h nzcv=%b, required no done", got.r, got[3:0]);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result_flags: got %h nzcv=%b, required %h nzcv=%b",
                             got.r, got[3:0], want.r, want[3:0]);
                end
            end
        end
    end

    // Drives one operation with a one-cycle start pulse; returns on the first RUN cycle.
    task automatic launch(input logic [31:0] a, b, input logic cf, input logic [3:0] s,
                          input logic m, input logic [1:0] sc, input logic rev, ca, cb,
                          input bit push, input exp_t e);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.c_flag = cf; bus.alu_s = s; bus.alu_m = m;
        bus.sel_c = sc; bus.reverse = rev; bus.clearA_bar = ca; bus.clearB_bar = cb;
        bus.start = 1'b1;
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        clear = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_flag = 1'b0; bus.alu_s = '0;
        bus.alu_m = 1'b0; bus.sel_c = '0; bus.reverse = 1'b0;
        bus.clearA_bar = 1'b1; bus.clearB_bar = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out, bus.busy, bus.done} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state: got result=%h nzcv=%b busy=%b done=%b, required all 0",
                     bus.result, {bus.n_out, bus.z_out, bus.c_out, bus.v_out}, bus.busy, bus.done);
        end
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith;
        int lat;
        launch(32'hFFFF_FFFF, 32'h1, 1'b0, 4'b1001, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'h0, 1'b0, 1'b1, 1'b1, 1'b0));
        vectors++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, required 1", bus.busy);
        end
        wait_done(lat);
        vectors++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles, required 8", lat);
        end
        launch(32'h8000_0000, 32'h1, 1'b0, 4'b0110, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1));
        wait_done(lat);
        launch(32'h5, 32'h3, 1'b0, 4'b0110, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1,
               mk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_done(lat);
        launch(32'h5, 32'h3, 1'b0, 4'b0110, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'h1, 1'b0, 1'b0, 1'b1, 1'b0));
        wait_done(lat);
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_on_done: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_logic;
        int lat;
        launch(32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 4'b1110, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'hF000_F000, 1'b1, 1'b0, 1'b1, 1'b0));
        wait_done(lat);
        launch(32'h1234_5678, 32'h0, 1'b0, 4'b0101, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1,
               mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_done(lat);
        launch(32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
               mk(32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0));
        wait_done(lat);
    endtask

    task automatic test_random;
        int lat;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic [3:0]  s;
            logic [1:0]  sc;
            logic        cf, m, rev, ca, cb;
            a = $urandom; b = $urandom; s = 4'($urandom); sc = 2'($urandom);
            cf = 1'($urandom); rev = 1'($urandom);
            m  = (i % 2 == 0);
            if (m && i % 4 == 0) s = 4'b1001;
            if (m && i % 4 == 2) s = 4'b0110;
            ca = ($urandom_range(0, 7) != 0);
            cb = ($urandom_range(0, 7) != 0);
            launch(a, b, cf, s, m, sc, rev, ca, cb, 1'b1, model(a, b, cf, s, m, sc, rev, ca, cb));
            wait_done(lat);
            vectors++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d cycles, required 8", i, lat);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        int extra;
        launch(32'h0000_1000, 32'h0000_0234, 1'b0, 4'b1001, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        bus.a = 32'hFFFF_0000; bus.b = 32'h0000_FFFF; bus.alu_s = 4'b1011; bus.alu_m = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        vectors++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d remaining cycles, required 5", lat);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0 || bus.result !== 32'h0000_1234) begin
            errors++;
            $display("FAIL busy_ignore_hold: got extra_done=%0d result=%h, required 0 and 00001234",
                     extra, bus.result);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(32'h0000_0010, 32'h0000_0003, 1'b0, 4'b0110, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'h0000_000D, 1'b0, 1'b0, 1'b1, 1'b0));
        wait_done(lat);
        bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555; bus.c_flag = 1'b0; bus.alu_s = 4'b1001;
        bus.alu_m = 1'b0; bus.sel_c = 2'b00; bus.reverse = 1'b0;
        bus.clearA_bar = 1'b1; bus.clearB_bar = 1'b1;
        bus.start = 1'b1;
        sb.push_back(mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.result !== 32'h0000_000D || bus.c_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got busy=%b result=%h c=%b, required 1 0000000d 1",
                     bus.busy, bus.result, bus.c_out);
        end
        wait_done(lat);
        vectors++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles, required 8", lat);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        launch(32'h1111_1111, 32'h2222_2222, 1'b1, 4'b1001, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0,
               mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        clear = 1'b0;
        #1;
        vectors++;
        if ({bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out, bus.busy, bus.done} !== 38'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: got result=%h nzcv=%b busy=%b done=%b, required all 0",
                     bus.result, {bus.n_out, bus.z_out, bus.c_out, bus.v_out}, bus.busy, bus.done);
        end
        @(negedge clk);
        clear = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d done pulses, required 0", seen);
        end
        launch(32'h0000_0007, 32'h0000_0009, 1'b0, 4'b1001, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
               mk(32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_done(lat);
        vectors++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d cycles, required 8", lat);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding results, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
